// File: rtl/sram_1rw1r_param_if.sv
// Bus bundle for the 1RW+1R SRAM model: port 0 read/write, port 1 read-only,
// plus the init-done indication. Clock and reset stay outside the bundle.
interface sram_1rw1r_param_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = 8
);
    localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

    logic                  ready;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  coll1;

    modport master (
        input  ready, dout0, dout1, coll1,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        output ready, dout0, dout1, coll1,
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1
    );
endinterface

// File: rtl/sram_1rw1r_param.sv
// Behavioural 1RW+1R SRAM: byte-lane masked writes on port 0, read-only
// port 1, configurable read latency (1 or 2) and port-1 collision policy.
// After reset an init sweep writes INIT_VALUE to every word before ready.
module sram_1rw1r_param #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 9,
    parameter int                    WMASK_WIDTH  = 8,
    parameter int                    READ_LATENCY = 1,
    parameter int                    WRITE_FIRST  = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input logic               clk0,
    input logic               rstb0,
    sram_1rw1r_param_if.slave bus
);
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_ready;
    logic                  w_init_we, w_run;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_p0_rd, w_p0_wr, w_p1_rd, w_coll;
    logic [DATA_WIDTH-1:0] w_old0, w_merged, w_p1_data;

    logic [DATA_WIDTH-1:0] r_s1_dout0, r_s1_dout1;
    logic                  r_s1_coll1;

    // State register, init counter and registered ready (rises with INIT->RUN)
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= (w_state_nxt == ST_RUN);
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
        end
    end

    // Next state: leave INIT after the sweep writes the last word
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_cnt == ADDR_WIDTH'(DEPTH - 1))
            w_state_nxt = ST_RUN;
    end

    // FSM outputs: init sweep write enable and access gate
    always_comb begin
        w_init_we = (r_state == ST_INIT);
        w_run     = (r_state == ST_RUN);
    end

    assign w_p0_rd = w_run && !bus.csb0 && bus.web0;
    assign w_p0_wr = w_run && !bus.csb0 && !bus.web0;
    assign w_p1_rd = w_run && !bus.csb1;
    assign w_coll  = w_p0_wr && w_p1_rd && (bus.addr0 == bus.addr1);

    // Lane merge of the port-0 write word; unmasked lanes keep old contents
    always_comb begin
        w_old0   = r_mem[bus.addr0];
        w_merged = w_old0;
        for (int i = 0; i < NUM_WMASKS; i++)
            if (bus.wmask0[i])
                w_merged[i*WMASK_WIDTH +: WMASK_WIDTH] = bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
    end

    // Port-1 data: on collision, write-first forwards the merged word
    always_comb begin
        w_p1_data = r_mem[bus.addr1];
        if (w_coll && (WRITE_FIRST != 0)) w_p1_data = w_merged;
    end

    // Array write: the init sweep owns the array until RUN (it also touches
    // word 0 while reset is held with the clock running, which INIT redoes anyway)
    always_ff @(posedge clk0) begin
        if (w_init_we)    r_mem[r_init_cnt] <= INIT_VALUE;
        else if (w_p0_wr) r_mem[bus.addr0]  <= w_merged;
    end

    // Read stage 1: capture on a sampled read, hold otherwise; collision pulses
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            r_s1_dout0 <= '0;
            r_s1_dout1 <= '0;
            r_s1_coll1 <= 1'b0;
        end else begin
            if (w_p0_rd) r_s1_dout0 <= w_old0;
            if (w_p1_rd) r_s1_dout1 <= w_p1_data;
            r_s1_coll1 <= w_coll;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] r_s2_dout0, r_s2_dout1;
            logic                  r_s2_coll1;

            // Read stage 2: a plain delay of stage 1, which already holds idle values
            always_ff @(posedge clk0 or negedge rstb0) begin
                if (!rstb0) begin
                    r_s2_dout0 <= '0;
                    r_s2_dout1 <= '0;
                    r_s2_coll1 <= 1'b0;
                end else begin
                    r_s2_dout0 <= r_s1_dout0;
                    r_s2_dout1 <= r_s1_dout1;
                    r_s2_coll1 <= r_s1_coll1;
                end
            end

            assign bus.dout0 = r_s2_dout0;
            assign bus.dout1 = r_s2_dout1;
            assign bus.coll1 = r_s2_coll1;
        end else begin : g_lat1
            assign bus.dout0 = r_s1_dout0;
            assign bus.dout1 = r_s1_dout1;
            assign bus.coll1 = r_s1_coll1;
        end
    endgenerate

    assign bus.ready = r_ready;
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench: three SRAM instances (lat1/write-first, lat1/read-first, lat2/write-first)
// receive identical stimulus; a scoreboard queue per instance holds expected reads.
module tb_sram_1rw1r_param;
    localparam int DW = 32, AW = 9, MW = 8, NM = 4, DEPTH = 512, ND = 3;

    logic clk0 = 1'b0;
    logic rstb0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic          t_csb0 = 1'b1, t_web0 = 1'b1, t_csb1 = 1'b1;
    logic [NM-1:0] t_wmask0 = '0;
    logic [AW-1:0] t_addr0 = '0, t_addr1 = '0;
    logic [DW-1:0] t_din0 = '0;

    sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) if_a(), if_b(), if_c();

    sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(1), .WRITE_FIRST(1))
        dut_a (.clk0(clk0), .rstb0(rstb0), .bus(if_a.slave));
    sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(1), .WRITE_FIRST(0))
        dut_b (.clk0(clk0), .rstb0(rstb0), .bus(if_b.slave));
    sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(2), .WRITE_FIRST(1))
        dut_c (.clk0(clk0), .rstb0(rstb0), .bus(if_c.slave));

    assign if_a.csb0 = t_csb0;   assign if_b.csb0 = t_csb0;   assign if_c.csb0 = t_csb0;
    assign if_a.web0 = t_web0;   assign if_b.web0 = t_web0;   assign if_c.web0 = t_web0;
    assign if_a.wmask0 = t_wmask0; assign if_b.wmask0 = t_wmask0; assign if_c.wmask0 = t_wmask0;
    assign if_a.addr0 = t_addr0; assign if_b.addr0 = t_addr0; assign if_c.addr0 = t_addr0;
    assign if_a.din0 = t_din0;   assign if_b.din0 = t_din0;   assign if_c.din0 = t_din0;
    assign if_a.csb1 = t_csb1;   assign if_b.csb1 = t_csb1;   assign if_c.csb1 = t_csb1;
    assign if_a.addr1 = t_addr1; assign if_b.addr1 = t_addr1; assign if_c.addr1 = t_addr1;

    logic [DW-1:0] obs_d0 [ND], obs_d1 [ND];
    logic          obs_c1 [ND], obs_rdy [ND];
    assign obs_d0[0] = if_a.dout0; assign obs_d0[1] = if_b.dout0; assign obs_d0[2] = if_c.dout0;
    assign obs_d1[0] = if_a.dout1; assign obs_d1[1] = if_b.dout1; assign obs_d1[2] = if_c.dout1;
    assign obs_c1[0] = if_a.coll1; assign obs_c1[1] = if_b.coll1; assign obs_c1[2] = if_c.coll1;
    assign obs_rdy[0] = if_a.ready; assign obs_rdy[1] = if_b.ready; assign obs_rdy[2] = if_c.ready;

    int lat [ND] = '{1, 1, 2};
    bit wf  [ND] = '{1'b1, 1'b0, 1'b1};

    typedef struct {
        int          due;
        logic        v0;
        logic [DW-1:0] d0;
        logic        v1;
        logic [DW-1:0] d1;
        logic        c1;
    } exp_t;

    exp_t          sbq [ND][$];
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] exp_d0 [ND], exp_d1 [ND];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    // Forget everything in flight and restart the model at the post-init image
    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            sbq[d].delete();
            exp_d0[d] = '0;
            exp_d1[d] = '0;
        end
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    task automatic set_idle();
        t_csb0 = 1'b1; t_web0 = 1'b1; t_wmask0 = '0; t_addr0 = '0; t_din0 = '0;
        t_csb1 = 1'b1; t_addr1 = '0;
    endtask

    // Scoreboard: pop entries due this cycle, then compare every RUN-mode output
    task automatic sb_step();
        exp_t e;
        logic c;
        for (int d = 0; d < ND; d++) begin
            c = 1'b0;
            while (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
                e = sbq[d].pop_front();
                if (e.v0) exp_d0[d] = e.d0;
                if (e.v1) exp_d1[d] = e.d1;
                if (e.c1) c = 1'b1;
            end
            checks++;
            if (obs_d0[d] !== exp_d0[d]) begin
                errors++;
                $display("FAIL sb_dout0 dut%0d cyc%0d: got %h want %h", d, cyc, obs_d0[d], exp_d0[d]);
            end
            checks++;
            if (obs_d1[d] !== exp_d1[d]) begin
                errors++;
                $display("FAIL sb_dout1 dut%0d cyc%0d: got %h want %h", d, cyc, obs_d1[d], exp_d1[d]);
            end
            checks++;
            if (obs_c1[d] !== c) begin
                errors++;
                $display("FAIL sb_coll1 dut%0d cyc%0d: got %b want %b", d, cyc, obs_c1[d], c);
            end
            checks++;
            if (obs_rdy[d] !== 1'b1) begin
                errors++;
                $display("FAIL sb_ready dut%0d cyc%0d: got %b want 1", d, cyc, obs_rdy[d]);
            end
        end
    endtask

    // One RUN-mode clock: drive, predict from the model, clock, check
    task automatic cycle(input logic cs0, input logic we0, input logic [NM-1:0] m,
                         input logic [AW-1:0] a0, input logic [DW-1:0] di,
                         input logic cs1, input logic [AW-1:0] a1);
        exp_t e;
        logic [DW-1:0] merged, old0, old1;
        logic rd0, wr0, rd1, coll;
        t_csb0 = cs0; t_web0 = we0; t_wmask0 = m; t_addr0 = a0; t_din0 = di;
        t_csb1 = cs1; t_addr1 = a1;
        old0 = mdl[a0];
        old1 = mdl[a1];
        merged = old0;
        for (int i = 0; i < NM; i++) if (m[i]) merged[i*MW +: MW] = di[i*MW +: MW];
        rd0  = !cs0 && we0;
        wr0  = !cs0 && !we0;
        rd1  = !cs1;
        coll = wr0 && rd1 && (a0 == a1);
        @(posedge clk0);
        cyc++;
        for (int d = 0; d < ND; d++) begin
            e.due = cyc + lat[d] - 1;
            e.v0  = rd0;
            e.d0  = old0;
            e.v1  = rd1;
            e.d1  = (coll && wf[d]) ? merged : old1;
            e.c1  = coll;
            sbq[d].push_back(e);
        end
        if (wr0) mdl[a0] = merged;
        #1;
        sb_step();
    endtask

    task automatic idle_cycle();
        cycle(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    endtask

    // Release reset and count edges until every instance reports ready; while
    // in INIT, optionally hammer addr 3 with a write and a port-1 read
    task automatic release_and_init(input bit hammer);
        int rdy_at [ND];
        bit all;
        for (int d = 0; d < ND; d++) rdy_at[d] = 0;
        set_idle();
        if (hammer) begin
            t_csb0 = 1'b0; t_web0 = 1'b0; t_wmask0 = '1; t_addr0 = 9'd3; t_din0 = 32'hDEADBEEF;
            t_csb1 = 1'b0; t_addr1 = 9'd3;
        end
        rstb0 = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk0);
            #1;
            all = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (rdy_at[d] == 0 && obs_rdy[d] === 1'b1) rdy_at[d] = n;
                if (rdy_at[d] == 0) all = 1'b0;
                if (rdy_at[d] == 0 && (n % 128) == 1) begin
                    checks++;
                    if (obs_d0[d] !== '0 || obs_d1[d] !== '0 || obs_c1[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL init_quiet dut%0d edge%0d: got %h/%h/%b want 0/0/0",
                                 d, n, obs_d0[d], obs_d1[d], obs_c1[d]);
                    end
                end
            end
            if (all) break;
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (rdy_at[d] != DEPTH) begin
                errors++;
                $display("FAIL init_edges dut%0d: got %0d want %0d", d, rdy_at[d], DEPTH);
            end
        end
        set_idle();
        model_clear();
    endtask

    task automatic test_reset();
        set_idle();
        rstb0 = 1'b0;
        repeat (2) @(posedge clk0);
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_rdy[d] !== 1'b0 || obs_d0[d] !== '0 || obs_d1[d] !== '0 || obs_c1[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got rdy=%b d0=%h d1=%h c=%b want 0", d,
                         obs_rdy[d], obs_d0[d], obs_d1[d], obs_c1[d]);
            end
        end
        release_and_init(1'b1);
    endtask

    // INIT-time writes to addr 3 are dropped; top address reads as INIT_VALUE
    task automatic test_init_ignore();
        cycle(1'b0, 1'b1, '0, 9'd3, '0, 1'b0, 9'd3);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_d0[d] !== 32'h0 || obs_d1[d] !== 32'h0) begin
                errors++;
                $display("FAIL init_ignored dut%0d: got %h/%h want 0", d, obs_d0[d], obs_d1[d]);
            end
        end
        cycle(1'b0, 1'b1, '0, 9'h1FF, '0, 1'b1, '0);
        idle_cycle();
    endtask

    task automatic test_wmask();
        cycle(1'b0, 1'b0, 4'b1111, 9'd5, 32'hFFFFFFFF, 1'b1, '0);
        cycle(1'b0, 1'b0, 4'b0101, 9'd5, 32'h12345678, 1'b1, '0);
        cycle(1'b0, 1'b0, 4'b0000, 9'd5, 32'h00000000, 1'b1, '0);
        cycle(1'b0, 1'b1, '0, 9'd5, '0, 1'b0, 9'd5);
        idle_cycle();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_d0[d] !== 32'hFF34FF78 || obs_d1[d] !== 32'hFF34FF78) begin
                errors++;
                $display("FAIL wmask_merge dut%0d: got %h/%h want ff34ff78", d, obs_d0[d], obs_d1[d]);
            end
        end
    endtask

    task automatic test_collision();
        cycle(1'b0, 1'b0, 4'b1111, 9'd7, 32'hAAAAAAAA, 1'b1, '0);
        idle_cycle();
        cycle(1'b0, 1'b0, 4'b1111, 9'd7, 32'h55555555, 1'b0, 9'd7);
        checks++;
        if (obs_d1[0] !== 32'h55555555 || obs_c1[0] !== 1'b1) begin
            errors++;
            $display("FAIL coll_write_first: got %h/%b want 55555555/1", obs_d1[0], obs_c1[0]);
        end
        checks++;
        if (obs_d1[1] !== 32'hAAAAAAAA || obs_c1[1] !== 1'b1) begin
            errors++;
            $display("FAIL coll_read_first: got %h/%b want aaaaaaaa/1", obs_d1[1], obs_c1[1]);
        end
        idle_cycle();
        checks++;
        if (obs_c1[0] !== 1'b0 || obs_c1[1] !== 1'b0 || obs_c1[2] !== 1'b1) begin
            errors++;
            $display("FAIL coll_pulse: got %b%b%b want 001", obs_c1[0], obs_c1[1], obs_c1[2]);
        end
        // no-collision cases: different address, port 0 reading, port 0 deselected
        cycle(1'b0, 1'b0, 4'b1111, 9'd8, 32'h01020304, 1'b0, 9'd7);
        cycle(1'b0, 1'b1, 4'b1111, 9'd7, 32'h0, 1'b0, 9'd7);
        cycle(1'b1, 1'b0, 4'b1111, 9'd7, 32'hFFFFFFFF, 1'b0, 9'd7);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] want [4] = '{32'h11, 32'h22, 32'h33, 32'h33};
        cycle(1'b0, 1'b0, 4'hF, 9'd1, 32'h11, 1'b1, '0);
        cycle(1'b0, 1'b0, 4'hF, 9'd2, 32'h22, 1'b1, '0);
        cycle(1'b0, 1'b0, 4'hF, 9'd3, 32'h33, 1'b1, '0);
        idle_cycle();
        cycle(1'b0, 1'b1, '0, 9'd3, '0, 1'b0, 9'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < 2) cycle(1'b0, 1'b1, '0, 9'(2 - i), '0, 1'b0, 9'(i + 2));
            else       idle_cycle();
            checks++;
            if (obs_d1[2] !== want[i]) begin
                errors++;
                $display("FAIL b2b_lat2 step%0d: got %h want %h", i, obs_d1[2], want[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
                  NM'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
                  logic'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)));
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        // abort INIT at count 100
        rstb0 = 1'b0;
        repeat (2) @(posedge clk0);
        #1;
        rstb0 = 1'b1;
        repeat (100) @(posedge clk0);
        #2;
        rstb0 = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_rdy[d] !== 1'b0) begin
                errors++;
                $display("FAIL mid_init_ready dut%0d: got %b want 0", d, obs_rdy[d]);
            end
        end
        repeat (2) @(posedge clk0);
        #1;
        release_and_init(1'b0);
        // abort RUN with a read in flight
        cycle(1'b0, 1'b0, 4'hF, 9'd9, 32'hCAFEF00D, 1'b1, '0);
        idle_cycle();
        cycle(1'b0, 1'b1, '0, 9'd9, '0, 1'b0, 9'd9);
        rstb0 = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_rdy[d] !== 1'b0 || obs_d0[d] !== '0 || obs_d1[d] !== '0 || obs_c1[d] !== 1'b0) begin
                errors++;
                $display("FAIL run_reset_async dut%0d: got rdy=%b d0=%h d1=%h want 0",
                         d, obs_rdy[d], obs_d0[d], obs_d1[d]);
            end
        end
        repeat (3) @(posedge clk0);
        #1;
        checks++;
        if (obs_d0[2] !== '0 || obs_d1[2] !== '0) begin
            errors++;
            $display("FAIL inflight_dropped: got %h/%h want 0", obs_d0[2], obs_d1[2]);
        end
        release_and_init(1'b0);
        cycle(1'b0, 1'b1, '0, 9'd9, '0, 1'b0, 9'd9);
        idle_cycle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_init_ignore();
        test_wmask();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
Parametrised behavioural SRAM model, the successor to the fixed 32x512 single-port model. It has one read/write port (port 0) with byte-lane write mask and one read-only port (port 1), both on a single clock. Read latency and same-address collision policy are configurable. A reset-driven init state machine clears the array before accesses are accepted. It is used as the user-project macro stand-in for RTL simulation and for wrapper bring-up.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of WMASK_WIDTH
ADDR_WIDTH, 9, address width; DEPTH = 1 << ADDR_WIDTH
WMASK_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH (derived)
READ_LATENCY, 1, read latency in cycles; legal values 1 or 2
WRITE_FIRST, 1, port-1 same-address collision policy: 1 = new data, 0 = old data
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during init

Ports:
clk0  in  1  clock, rising-edge
rstb0  in  1  reset, asynchronous, active-low
ready  out  1  high when init is done and accesses are accepted
csb0  in  1  port 0 chip select, active-low
web0  in  1  port 0 write enable, active-low
wmask0  in  NUM_WMASKS  port 0 lane write mask, 1 = write lane
addr0  in  ADDR_WIDTH  port 0 address
din0  in  DATA_WIDTH  port 0 write data
dout0  out  DATA_WIDTH  port 0 read data
csb1  in  1  port 1 chip select, active-low
addr1  in  ADDR_WIDTH  port 1 address
dout1  out  DATA_WIDTH  port 1 read data
coll1  out  1  port 1 same-address collision flag, aligned with dout1

Behaviour:
- Reset (rstb0 low, asynchronous):
  - ready=0, dout0=0, dout1=0, coll1=0.
  - Read pipeline registers cleared.
  - FSM enters INIT with init counter = 0.
  - Array contents are not cleared by reset itself; INIT overwrites them.
- FSM states:
  - INIT: each rising edge writes INIT_VALUE to mem[counter] and increments the counter. The write at counter = DEPTH-1 moves the FSM to RUN. INIT takes exactly DEPTH edges after rstb0 deasserts.
  - RUN: ready=1. Leaves RUN only on reset.
- ready is a registered output. It rises on the same edge as the INIT->RUN transition.
- In INIT, csb0/csb1 are ignored: no array access, douts hold 0, coll1=0.
- Port 0 write (RUN, csb0=0, web0=0, sampled at edge N):
  - Lane i written from din0 lane i only where wmask0[i]=1; other lanes are unchanged.
  - The new value is visible to any read sampled at edge N+1 or later.
  - wmask0 = all zeros is a legal no-op write.
- Reads (port 0 with csb0=0, web0=1; port 1 with csb1=0; sampled at edge N):
  - READ_LATENCY=1: dout updates at edge N.
  - READ_LATENCY=2: dout updates at edge N+1 (extra output register stage).
  - Each port's pipeline is fully pipelined and accepts a new read every cycle.
- dout0/dout1 hold their last read value when idle or while port 0 writes. They never go X.
- Collision: a port 0 write and a port 1 read to the same address sampled on the same edge.
  - WRITE_FIRST=1: dout1 = merged word (masked lanes from din0, other lanes old).
  - WRITE_FIRST=0: dout1 = pre-write word.
  - coll1 pulses high for one cycle, on the same edge dout1 presents that read.
  - No collision is flagged when csb0=1, web0=1 or the addresses differ.
- Address wraps naturally: no out-of-range addresses exist.
- Reset asserted mid-INIT or mid-RUN aborts in-flight reads (their data is never presented) and restarts INIT from address 0.
- No X propagation from undriven array words after INIT.

Test Plan:
1. Release rstb0; count edges -> ready rises after exactly 512 edges (default). A read of addr 0x1FF then returns 0x00000000 with dout0 valid one cycle after sampling at latency 1.
2. Write 0xFFFFFFFF to addr 5 with wmask0=4'b1111, then write 0x12345678 with wmask0=4'b0101 -> port 0 and port 1 reads of addr 5 return 0xFF34FF78.
3. WRITE_FIRST=1: addr 7 holds 0xAAAAAAAA; write 0x55555555 with mask 4'b1111 and read addr 7 on port 1 on the same edge -> dout1=0x55555555, coll1=1 for one cycle. Same stimulus with WRITE_FIRST=0 -> dout1=0xAAAAAAAA, coll1=1.
4. READ_LATENCY=2, back-to-back port 1 reads of addrs 1, 2, 3 holding 0x11, 0x22, 0x33 -> dout1 shows 0x11, 0x22, 0x33 on consecutive edges starting one edge after the first sample; dout1 then holds 0x33 while idle.
5. Drive a write to addr 3 with csb0=0 during INIT -> it is ignored. After ready, a read of addr 3 returns INIT_VALUE.
6. Assert rstb0 at INIT count 100, and again in RUN with a read in flight -> dout0/dout1/ready drop to 0 immediately with no clock. The in-flight read never appears. After release, ready rises again after 512 edges.
